spi_slave_frame: RTL and testbench

SPI responder that receives and transmits one frame of six 16-bit words, MSB first, in SPI mode 0. It is the far-end counterpart of the Nios-side SPI master and its six TX/RX word registers. It is used as the loopback/emulation target for the DSP link, and as the FPGA-side slave when the DSP is master. All SPI inputs are oversampled in the `clk_clk` domain; the block contains no logic clocked by SCLK.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_frame.sv | 189 ++++++++++++++++++
 tb/tb_spi_slave_frame.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame responder: default geometry and FSM states.
package spi_pkg;

    localparam int unsigned WORD_W_DEF      = 16;
    localparam int unsigned N_WORDS_DEF     = 6;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin, with single-cycle rise/fall pulses.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int unsigned STAGES  = SYNC_STAGES_DEF,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level  = r_sync[STAGES-1];
    assign o_rise_c = r_sync[STAGES-1] & ~r_prev;
    assign o_fall_c = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_frame.sv
// SPI mode-0 responder: one frame of N_WORDS words, MSB first, all pins oversampled in clk_clk.
module spi_slave_frame
    import spi_pkg::*;
#(
    parameter int unsigned WORD_W      = WORD_W_DEF,
    parameter int unsigned N_WORDS     = N_WORDS_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic                        spi_sclk,
    input  logic                        spi_cs_n,
    input  logic                        spi_mosi,
    output logic                        spi_miso,
    output logic                        spi_miso_oe,
    input  logic [N_WORDS*WORD_W-1:0]   tx_data,
    output logic [N_WORDS*WORD_W-1:0]   rx_data,
    output logic [3:0]                  rx_count,
    output logic                        rx_valid,
    output logic                        frame_err,
    output logic                        busy
);

    localparam int unsigned FRAME_W = N_WORDS * WORD_W;
    localparam int unsigned BIT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_cs_s, w_cs_rise, w_cs_fall;
    logic w_mosi_s;

    spi_state_e          r_state;
    logic [FRAME_W-1:0]  r_shadow;
    logic [FRAME_W-1:0]  r_stage;
    logic [FRAME_W-1:0]  r_rx_data;
    logic [WORD_W-1:0]   r_rx_shift;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [3:0]          r_word_cnt;
    logic [3:0]          r_rx_count;
    logic                r_ovr;
    logic                r_rx_valid;
    logic                r_frame_err;
    logic                r_miso;
    logic                r_miso_oe;
    logic                r_busy;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic [WORD_W-1:0]   w_cur_word;
    logic [WORD_W-1:0]   w_shift_next;
    logic [BIT_W-1:0]    w_bit_idx;
    logic                w_next_bit;

    // SCLK idles low; CS_n resets low so RESYNC only leaves once the pin is truly high.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .i_d      (spi_sclk),
        .o_level  (w_sclk_s),
        .o_rise_c (w_sclk_rise),
        .o_fall_c (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .i_d      (spi_cs_n),
        .o_level  (w_cs_s),
        .o_rise_c (w_cs_rise),
        .o_fall_c (w_cs_fall)
    );

    // MOSI gets the same depth as SCLK so the sampled bit lines up with the detected rise.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // Current tx word; reads as zero once every word has been sent.
    always_comb begin
        w_cur_word = '0;
        for (int k = 0; k < int'(N_WORDS); k++) begin
            if (r_word_cnt == 4'(k)) begin
                w_cur_word = r_shadow[k*WORD_W +: WORD_W];
            end
        end
    end

    assign w_shift_next = {r_rx_shift[WORD_W-2:0], w_mosi_s};
    assign w_bit_idx    = BIT_W'(WORD_W - 1) - r_bit_cnt;
    assign w_next_bit   = w_cur_word[w_bit_idx];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= RESYNC;
            r_shadow    <= '0;
            r_stage     <= '0;
            r_rx_data   <= '0;
            r_rx_shift  <= '0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_rx_count  <= '0;
            r_ovr       <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                RESYNC: begin
                    if (w_cs_s) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (w_cs_fall) begin
                        r_shadow   <= tx_data;
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                        r_ovr      <= 1'b0;
                        r_miso     <= tx_data[WORD_W-1];
                        r_miso_oe  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // CS release takes priority over a coincident SCLK edge.
                    if (w_cs_rise) begin
                        r_miso    <= 1'b0;
                        r_miso_oe <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= DONE;
                    end else begin
                        if (w_sclk_rise) begin
                            if (r_word_cnt == 4'(N_WORDS)) begin
                                r_ovr <= 1'b1;
                            end else if (r_bit_cnt == BIT_W'(WORD_W - 1)) begin
                                for (int k = 0; k < int'(N_WORDS); k++) begin
                                    if (r_word_cnt == 4'(k)) begin
                                        r_stage[k*WORD_W +: WORD_W] <= w_shift_next;
                                    end
                                end
                                r_rx_shift <= w_shift_next;
                                r_bit_cnt  <= '0;
                                r_word_cnt <= r_word_cnt + 4'd1;
                            end else begin
                                r_rx_shift <= w_shift_next;
                                r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
                            end
                        end
                        if (w_sclk_fall) begin
                            r_miso <= w_next_bit;
                        end
                    end
                end
                DONE: begin
                    // Only complete words reach rx_data; the rest keep the previous frame.
                    for (int k = 0; k < int'(N_WORDS); k++) begin
                        if (4'(k) < r_word_cnt) begin
                            r_rx_data[k*WORD_W +: WORD_W] <= r_stage[k*WORD_W +: WORD_W];
                        end
                    end
                    r_rx_count  <= r_word_cnt;
                    r_frame_err <= (r_bit_cnt != '0) | r_ovr;
                    r_rx_valid  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= RESYNC;
                end
            endcase
        end
    end

    assign spi_miso    = r_miso;
    assign spi_miso_oe = r_miso_oe;
    assign rx_data     = r_rx_data;
    assign rx_count    = r_rx_count;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_spi_slave_frame.sv
// Directed bench for spi_slave_frame: acts as a mode-0 master at SCLK = clk/8.
module tb_spi_slave_frame;

    localparam int W  = 16;
    localparam int N  = 6;
    localparam int FW = W * N;

    logic          clk_clk;
    logic          reset_reset_n;
    logic          spi_sclk;
    logic          spi_cs_n;
    logic          spi_mosi;
    logic          spi_miso;
    logic          spi_miso_oe;
    logic [FW-1:0] tx_data;
    logic [FW-1:0] rx_data;
    logic [3:0]    rx_count;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    int tests     = 0;
    int fails     = 0;
    int valid_cnt = 0;

    localparam logic [FW-1:0] M1 = {16'h1234, 16'hFFFF, 16'h5A5A, 16'hA5A5, 16'h8000, 16'h0001};
    localparam logic [FW-1:0] T1 = {16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'hDEAD};
    localparam logic [FW-1:0] M2 = {16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    localparam logic [FW-1:0] M3 = {16'h0F0F, 16'hF0F0, 16'hC3C3, 16'h3C3C, 16'h7E7E, 16'h8181};

    spi_slave_frame dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .spi_sclk      (spi_sclk),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .tx_data       (tx_data),
        .rx_data       (rx_data),
        .rx_count      (rx_count),
        .rx_valid      (rx_valid),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    always @(negedge clk_clk) begin
        if (rx_valid === 1'b1) valid_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pos(input int b);
        return (b / W) * W + (W - 1) - (b % W);
    endfunction

    // Clocks nbits bits; bits past the frame drive MOSI high and OR their MISO into extra_hi.
    task automatic run_frame(input int nbits, input logic [FW-1:0] mo, input int chg_at,
                             output logic [FW-1:0] mi, output logic extra_hi);
        mi       = '0;
        extra_hi = 1'b0;
        spi_cs_n = 1'b0;
        cycles(2);
        for (int b = 0; b < nbits; b++) begin
            if (b == chg_at) tx_data = '0;
            spi_mosi = (b < FW) ? mo[pos(b)] : 1'b1;
            cycles(4);
            if (b < FW) mi[pos(b)] = spi_miso;
            else        extra_hi = extra_hi | spi_miso;
            spi_sclk = 1'b1;
            cycles(4);
            spi_sclk = 1'b0;
        end
        cycles(4);
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input logic [3:0] cnt, input logic err,
                              input logic [FW-1:0] data);
        int n;
        n = 0;
        while (rx_valid !== 1'b1 && n < 40) begin
            cycles(1);
            n++;
        end
        chk({tag, "_valid"}, FW'(rx_valid), FW'(1));
        chk({tag, "_count"}, FW'(rx_count), FW'(cnt));
        chk({tag, "_err"},   FW'(frame_err), FW'(err));
        chk({tag, "_data"},  rx_data, data);
        cycles(1);
        chk({tag, "_pulse"}, FW'(rx_valid), FW'(0));
        chk({tag, "_oe"},    FW'(spi_miso_oe), FW'(0));
        cycles(4);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_miso"},  FW'(spi_miso), FW'(0));
        chk({tag, "_oe"},    FW'(spi_miso_oe), FW'(0));
        chk({tag, "_rxd"},   rx_data, '0);
        chk({tag, "_cnt"},   FW'(rx_count), FW'(0));
        chk({tag, "_valid"}, FW'(rx_valid), FW'(0));
        chk({tag, "_err"},   FW'(frame_err), FW'(0));
        chk({tag, "_busy"},  FW'(busy), FW'(0));
    endtask

    initial begin
        logic [FW-1:0] mi;
        logic          extra;
        logic          busy_seen;
        int            v0;

        reset_reset_n = 1'b0;
        spi_sclk      = 1'b0;
        spi_cs_n      = 1'b1;
        spi_mosi      = 1'b0;
        tx_data       = T1;
        cycles(3);
        chk_reset("rst");
        reset_reset_n = 1'b1;
        cycles(8);

        // Full frame, both directions.
        run_frame(96, M1, -1, mi, extra);
        chk("full_miso", mi, T1);
        wait_valid("full", 4'd6, 1'b0, M1);

        // CS pulse with no SCLK.
        spi_cs_n = 1'b0;
        cycles(10);
        spi_cs_n = 1'b1;
        wait_valid("zero", 4'd0, 1'b0, M1);

        // Two words plus five bits.
        run_frame(37, M2, -1, mi, extra);
        chk("short_miso", FW'(mi[31:0]), FW'(T1[31:0]));
        wait_valid("short", 4'd2, 1'b1, {M1[FW-1:32], M2[31:0]});

        // Three clocks past the last word.
        run_frame(99, M3, -1, mi, extra);
        chk("ovr_miso", mi, T1);
        chk("ovr_extra_miso", FW'(extra), FW'(0));
        wait_valid("ovr", 4'd6, 1'b1, M3);

        // tx_data cleared mid-frame: snapshot still sent, next frame sends zeros.
        run_frame(96, M1, 20, mi, extra);
        chk("snap_miso", mi, T1);
        wait_valid("snap", 4'd6, 1'b0, M1);
        run_frame(96, M2, -1, mi, extra);
        chk("zero_tx_miso", mi, '0);
        wait_valid("zero_tx", 4'd6, 1'b0, M2);

        // Reset in the middle of a frame, released while CS is still low.
        tx_data  = T1;
        spi_cs_n = 1'b0;
        cycles(6);
        for (int b = 0; b < 8; b++) begin
            spi_sclk = 1'b1; cycles(4);
            spi_sclk = 1'b0; cycles(4);
        end
        reset_reset_n = 1'b0;
        cycles(2);
        chk_reset("mid_rst");
        reset_reset_n = 1'b1;
        v0        = valid_cnt;
        busy_seen = 1'b0;
        for (int b = 0; b < 10; b++) begin
            spi_sclk = 1'b1; cycles(4);
            busy_seen = busy_seen | busy | spi_miso_oe;
            spi_sclk = 1'b0; cycles(4);
            busy_seen = busy_seen | busy | spi_miso_oe;
        end
        spi_cs_n = 1'b1;
        cycles(10);
        chk("mid_busy", FW'(busy_seen), FW'(0));
        chk("mid_no_valid", FW'(valid_cnt), FW'(v0));
        run_frame(96, M3, -1, mi, extra);
        chk("post_rst_miso", mi, T1);
        wait_valid("post_rst", 4'd6, 1'b0, M3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
